// File: rtl/piezo_keyboard.sv
// piezo_keyboard: eight-key square-wave tone generator with 7-segment note display.
// Define PIEZO_SUSTAIN_EN to keep the last note sounding for SUSTAIN_CYCLES after release.
module piezo_keyboard #(
  parameter int DIV_SHIFT      = 0,
  parameter int SUSTAIN_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic [1:0] octave,
  output logic [7:0] FND_out,
  output logic       piezo_out
);
`ifdef PIEZO_SUSTAIN_EN
  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;
  localparam int SW = $clog2(SUSTAIN_CYCLES + 1);
  logic [SW-1:0] sus_q, sus_d;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
  logic unused_sus;
  assign unused_sus = ^SUSTAIN_CYCLES;
`endif
  localparam logic [16:0] BASE [8] = '{17'd95556, 17'd85131, 17'd75843, 17'd71586,
                                       17'd63776, 17'd56818, 17'd50619, 17'd47778};
  localparam logic [7:0] CODE [8] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};
  state_t      state_q, state_d;
  logic [7:0]  sw_q, fnd_q, fnd_d;
  logic [1:0]  oct_q, noct_q, noct_d;
  logic [2:0]  note_q, note_d, idx;
  logic [16:0] cnt_q, cnt_d, h_raw, hp;
  logic        pz_q, pz_d, act, chg, tick;
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (sw_q[i]) idx = 3'(i);
  end
  // Tone timing follows the latched (sounding) note, not the live keys.
  assign h_raw = BASE[note_q] >> (DIV_SHIFT + int'(noct_q));
  assign hp    = (h_raw < 17'd2) ? 17'd2 : h_raw;
  assign act   = |sw_q;
  assign chg   = (idx != note_q) || (oct_q != noct_q);
  assign tick  = cnt_q == hp - 17'd1;
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    noct_d  = noct_q;
    cnt_d   = tick ? 17'd0 : cnt_q + 17'd1;
    pz_d    = pz_q ^ tick;
`ifdef PIEZO_SUSTAIN_EN
    sus_d   = sus_q + SW'(1);
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 17'd0;
        pz_d  = 1'b0;
        if (act) begin
          state_d = PLAY;
          note_d  = idx;
          noct_d  = oct_q;
        end
      end
      PLAY:
        if (!act) begin
`ifdef PIEZO_SUSTAIN_EN
          state_d = SUSTAIN;
          sus_d   = '0;
`else
          state_d = IDLE;
          cnt_d   = 17'd0;
          pz_d    = 1'b0;
`endif
        end else if (chg) begin
          note_d = idx;
          noct_d = oct_q;
          cnt_d  = 17'd0;
          pz_d   = 1'b0;
        end
`ifdef PIEZO_SUSTAIN_EN
      SUSTAIN:
        if (act) begin
          state_d = PLAY;
          if (chg) begin
            note_d = idx;
            noct_d = oct_q;
            cnt_d  = 17'd0;
            pz_d   = 1'b0;
          end
        end else if (sus_q == SW'(SUSTAIN_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = 17'd0;
          pz_d    = 1'b0;
        end
`endif
      default: state_d = IDLE;
    endcase
    // Display is derived from next state so it lands 2 clocks after sw.
    fnd_d = (state_d == IDLE) ? 8'h00 : {CODE[note_d][7:1], noct_d != 2'd0};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sw_q    <= 8'd0;
      oct_q   <= 2'd0;
      note_q  <= 3'd0;
      noct_q  <= 2'd0;
      cnt_q   <= 17'd0;
      pz_q    <= 1'b0;
      fnd_q   <= 8'h00;
`ifdef PIEZO_SUSTAIN_EN
      sus_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sw_q    <= sw;
      oct_q   <= octave;
      note_q  <= note_d;
      noct_q  <= noct_d;
      cnt_q   <= cnt_d;
      pz_q    <= pz_d;
      fnd_q   <= fnd_d;
`ifdef PIEZO_SUSTAIN_EN
      sus_q   <= sus_d;
`endif
    end
  end
  assign FND_out   = fnd_q;
  assign piezo_out = pz_q;
endmodule

// File: tb/tb_piezo_keyboard.sv
// tb_piezo_keyboard: checks piezo_keyboard tones and display against an arithmetic note model.
module tb_piezo_keyboard;
  localparam int DS = 10;
  localparam int SC = 50;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'd0;
  logic [1:0] octave = 2'd0;
  logic [7:0] FND_out;
  logic       piezo_out;
  int total = 0;
  int bad = 0;
  int prev_idx = -1;
  int prev_oct = 0;
  int base [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
  logic [7:0] code [8] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};

  always #10 clk = ~clk;

  piezo_keyboard #(.DIV_SHIFT(DS), .SUSTAIN_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .octave(octave),
    .FND_out(FND_out), .piezo_out(piezo_out)
  );

  function automatic int lowest(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic int half(input int k, input int o);
    int h;
    h = base[k] >> (DS + o);
    return (h < 2) ? 2 : h;
  endfunction

  function automatic logic [7:0] disp(input int k, input int o);
    return code[k] | {7'd0, o != 0};
  endfunction

  // Tone must restart at phase 0 two edges after the stimulus and toggle every H clocks.
  task automatic play(input logic [7:0] s, input logic [1:0] o, input int n_cyc);
    int k, h;
    logic e;
    k = lowest(s);
    h = half(k, int'(o));
    @(posedge clk); #1 sw = s; octave = o;
    repeat (2) @(posedge clk);
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      if (n == 0) begin
        total++;
        if (FND_out !== disp(k, int'(o))) begin
          bad++;
          $display("FAIL fnd sw=%h oct=%0d got=%h exp=%h", s, o, FND_out, disp(k, int'(o)));
        end
      end
      e = 1'((n / h) % 2);
      total++;
      if (piezo_out !== e) begin
        bad++;
        $display("FAIL tone sw=%h oct=%0d n=%0d got=%b exp=%b", s, o, n, piezo_out, e);
      end
    end
    prev_idx = k;
    prev_oct = int'(o);
  endtask

  task automatic test_reset;
    sw = 8'hFF; octave = 2'd3; rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (FND_out !== 8'h00 || piezo_out !== 1'b0) begin
        bad++;
        $display("FAIL reset fnd=%h pz=%b exp fnd=00 pz=0", FND_out, piezo_out);
      end
    end
    sw = 8'd0; octave = 2'd0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single;
    play(8'h01, 2'd0, 2 * half(0, 0) + 5);
  endtask

  task automatic test_priority;
    play(8'h28, 2'd0, 2 * half(3, 0) + 3);
    play(8'h20, 2'd0, 2 * half(5, 0) + 3);
    play(8'h20, 2'd2, 2 * half(5, 2) + 3);
  endtask

  task automatic test_octave;
    play(8'h80, 2'd3, 30);
  endtask

  task automatic test_release;
`ifdef PIEZO_SUSTAIN_EN
    @(posedge clk); #1 sw = 8'd0;
    repeat (2) @(posedge clk);
    for (int n = 0; n <= SC; n++) begin
      @(negedge clk);
      if (n < SC) begin
        total++;
        if (FND_out !== disp(prev_idx, prev_oct)) begin
          bad++;
          $display("FAIL sustain_fnd n=%0d got=%h exp=%h", n, FND_out, disp(prev_idx, prev_oct));
        end
      end else begin
        total++;
        if (FND_out !== 8'h00 || piezo_out !== 1'b0) begin
          bad++;
          $display("FAIL sustain_end fnd=%h pz=%b exp fnd=00 pz=0", FND_out, piezo_out);
        end
      end
    end
`else
    @(posedge clk); #1 sw = 8'd0;
    repeat (2) @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      total++;
      if (FND_out !== 8'h00 || piezo_out !== 1'b0) begin
        bad++;
        $display("FAIL release n=%0d fnd=%h pz=%b exp fnd=00 pz=0", n, FND_out, piezo_out);
      end
    end
`endif
    prev_idx = -1;
  endtask

`ifdef PIEZO_SUSTAIN_EN
  task automatic test_repress;
    play(8'h04, 2'd1, 2 * half(2, 1) + 3);
    @(posedge clk); #1 sw = 8'd0;
    repeat (20) @(posedge clk);
    play(8'h10, 2'd1, 2 * half(4, 1) + 3);
  endtask
`endif

  task automatic test_walk;
    for (int i = 0; i < 8; i++) play(8'(1 << i), 2'd0, 198);
  endtask

  task automatic test_mid_reset;
    int h;
    logic e;
    h = half(prev_idx, prev_oct);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      total++;
      if (FND_out !== 8'h00 || piezo_out !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset n=%0d fnd=%h pz=%b exp fnd=00 pz=0", n, FND_out, piezo_out);
      end
    end
    for (int n = 0; n < 2 * h + 3; n++) begin
      @(negedge clk);
      if (n == 0) begin
        total++;
        if (FND_out !== disp(prev_idx, prev_oct)) begin
          bad++;
          $display("FAIL mid_reset_fnd got=%h exp=%h", FND_out, disp(prev_idx, prev_oct));
        end
      end
      e = 1'((n / h) % 2);
      total++;
      if (piezo_out !== e) begin
        bad++;
        $display("FAIL mid_reset_tone n=%0d got=%b exp=%b", n, piezo_out, e);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] s;
    logic [1:0] o;
    int k;
    for (int it = 0; it < 10; it++) begin
      s = 8'($urandom_range(1, 255));
      o = 2'($urandom_range(0, 3));
      k = lowest(s);
      if (k == prev_idx && int'(o) == prev_oct) o = o + 2'd1;
      play(s, o, 2 * half(k, int'(o)) + 3);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_octave;
    test_release;
`ifdef PIEZO_SUSTAIN_EN
    test_repress;
    test_release;
`endif
    test_walk;
    test_mid_reset;
    test_random;
    test_release;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piezo_keyboard.md
PIEZO_KEYBOARD -- requirements
Module: piezo_keyboard

Interface
REQ-001 Parameter DIV_SHIFT, default 0: right-shift applied to every half-period table entry; values above 0 shorten simulation time.
REQ-002 Parameter SUSTAIN_CYCLES, default 25000000: number of release-sustain clocks, used only when PIEZO_SUSTAIN_EN is defined.
REQ-003 Port clk, input, 1: single clock, 50 MHz nominal; all logic is clocked on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port sw, input, 8: key switches; sw[k] requests note k (0=C4 … 7=C5).
REQ-006 Port octave, input, 2: octave raise applied to the active note, 0..3.
REQ-007 Port FND_out, output, 8: {a,b,c,d,e,f,g,dp}, active-high seven-segment pattern.
REQ-008 Port piezo_out, output, 1: square-wave tone output.

Function
REQ-009 sw and octave SHALL be registered once (sw_q, oct_q); all decisions SHALL use the registered copies.
REQ-010 The active key SHALL be the lowest set index of sw_q; sw_q==0 means no key.
REQ-011 Base half-periods in clocks, k=0..7: 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778.
REQ-012 Effective half-period H SHALL be base >> (DIV_SHIFT + oct_q), computed at 17-bit width with a floor of 2.
REQ-013 The FSM SHALL have states IDLE, PLAY and SUSTAIN.
REQ-014 Transition IDLE->PLAY SHALL occur when a key is active.
REQ-015 Transition PLAY->IDLE SHALL occur on release of all keys when the macro is absent; PLAY->SUSTAIN SHALL occur on release when the macro is present.
REQ-016 In PLAY or SUSTAIN, the half-period counter SHALL count 0..H-1; at H-1 it SHALL wrap to 0 and toggle piezo_out.
REQ-017 A change of note index or oct_q while sounding SHALL clear the counter and drive piezo_out to 0 in the same cycle; the new tone then starts from phase 0.
REQ-018 In IDLE, piezo_out SHALL be 0 and the counter SHALL be held at 0.
REQ-019 FND_out SHALL be registered from the current state and note, giving 2 clocks of latency from sw to FND_out.
REQ-020 Digit codes for notes 1..8 (k+1): 0x60, 0xDA, 0xF2, 0x66, 0xB6, 0xBE, 0xE0, 0xFE.
REQ-021 dp (bit 0) SHALL be 1 when oct_q != 0 and the block is sounding.
REQ-022 In IDLE, FND_out SHALL be 0x00.
REQ-023 Simultaneous keys SHALL follow the priority rule in REQ-010; releasing the winning key while another is held SHALL be treated as a note change, not a release.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE, counters=0, sw_q=0, oct_q=0, piezo_out=0, FND_out=0x00.
REQ-025 Reset asserted mid-tone or mid-sustain SHALL take effect at the next edge with no residual toggle.

Configuration
REQ-026 With PIEZO_SUSTAIN_EN defined, the SUSTAIN state SHALL keep the last note and octave sounding and displayed for SUSTAIN_CYCLES clocks, then move to IDLE.
REQ-027 With PIEZO_SUSTAIN_EN defined, a key press during SUSTAIN SHALL move the FSM to PLAY immediately, applying REQ-017 if the note differs.
REQ-028 Without PIEZO_SUSTAIN_EN, the SUSTAIN state and its counter SHALL not be generated, and release SHALL silence the output within 2 clocks of sw falling.

Verification
REQ-029 DIV_SHIFT=10, sw=0x01, octave=0 -> H=93; piezo_out period 186 clocks; FND_out=0x60 2 clocks after sw changes.
REQ-030 sw=0x28 -> note 3 (F) wins; FND_out=0x66; after sw changes to 0x20, FND_out=0xBE and piezo_out restarts from 0.
REQ-031 sw=0x80, octave=3, DIV_SHIFT=10 -> H=5; dp=1; FND_out=0xFF.
REQ-032 Macro on, SUSTAIN_CYCLES=50: play then release -> tone persists 50 clocks, then FND_out=0x00 and piezo_out=0; re-press at clock 20 of sustain -> PLAY.
REQ-033 rst_n=0 for 1 clock mid-tone -> all outputs 0 at the next edge; silence until a key is seen again.
REQ-034 sw walked one-hot 0x01->0x80, every 4000 ns -> FND sequence 0x60..0xFE with no stale-note toggles.
